// File: rtl/itlb_maint_if.sv
// ITLB maintenance bus: software MSR write side in, IMMU write ports and flush status out.
interface itlb_maint_if #(
  parameter int unsigned CONFIG_DW          = 32,
  parameter int unsigned CONFIG_ITLB_P_SETS = 7
);
  logic                          flush_req;
  logic                          sw_tlbl_we;
  logic [CONFIG_ITLB_P_SETS-1:0] sw_tlbl_idx;
  logic [CONFIG_DW-1:0]          sw_tlbl_nxt;
  logic                          sw_tlbh_we;
  logic [CONFIG_ITLB_P_SETS-1:0] sw_tlbh_idx;
  logic [CONFIG_DW-1:0]          sw_tlbh_nxt;
  logic                          tlbl_we;
  logic [CONFIG_ITLB_P_SETS-1:0] tlbl_idx;
  logic [CONFIG_DW-1:0]          tlbl_nxt;
  logic                          tlbh_we;
  logic [CONFIG_ITLB_P_SETS-1:0] tlbh_idx;
  logic [CONFIG_DW-1:0]          tlbh_nxt;
  logic                          fetch_hold;
  logic                          flush_busy;
  logic                          flush_done;

  modport master (
    output flush_req, sw_tlbl_we, sw_tlbl_idx, sw_tlbl_nxt,
           sw_tlbh_we, sw_tlbh_idx, sw_tlbh_nxt,
    input  tlbl_we, tlbl_idx, tlbl_nxt, tlbh_we, tlbh_idx, tlbh_nxt,
           fetch_hold, flush_busy, flush_done
  );

  modport slave (
    input  flush_req, sw_tlbl_we, sw_tlbl_idx, sw_tlbl_nxt,
           sw_tlbh_we, sw_tlbh_idx, sw_tlbh_nxt,
    output tlbl_we, tlbl_idx, tlbl_nxt, tlbh_we, tlbh_idx, tlbh_nxt,
           fetch_hold, flush_busy, flush_done
  );
endinterface

// File: rtl/itlb_maint_ctrl.sv
// ITLB maintenance sequencer: merges software TLBL/TLBH writes with a
// flush-all walker onto the IMMU write ports and holds fetch during a flush.
module itlb_maint_ctrl #(
  parameter int unsigned CONFIG_DW          = 32,
  parameter int unsigned CONFIG_ITLB_P_SETS = 7
) (
  input  logic         clk,
  input  logic         rst,
  itlb_maint_if.slave  bus
);
  localparam int unsigned P  = CONFIG_ITLB_P_SETS;
  localparam int unsigned DW = CONFIG_DW;
  localparam logic [P-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  state_t         state_q, state_d;
  logic [P-1:0]   cnt_q, cnt_d;

  logic           tlbl_we_q, tlbl_we_d;
  logic [P-1:0]   tlbl_idx_q, tlbl_idx_d;
  logic [DW-1:0]  tlbl_nxt_q, tlbl_nxt_d;
  logic           tlbh_we_q;
  logic [P-1:0]   tlbh_idx_q;
  logic [DW-1:0]  tlbh_nxt_q;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // State, set counter and all output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tlbl_we_q  <= 1'b0;
      tlbl_idx_q <= '0;
      tlbl_nxt_q <= '0;
      tlbh_we_q  <= 1'b0;
      tlbh_idx_q <= '0;
      tlbh_nxt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tlbl_we_q  <= tlbl_we_d;
      tlbl_idx_q <= tlbl_idx_d;
      tlbl_nxt_q <= tlbl_nxt_d;
      tlbh_we_q  <= bus.sw_tlbh_we;
      tlbh_idx_q <= bus.sw_tlbh_idx;
      tlbh_nxt_q <= bus.sw_tlbh_nxt;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state and TLBL port arbitration; software writes always win the slot.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tlbl_we_d  = bus.sw_tlbl_we;
    tlbl_idx_d = bus.sw_tlbl_idx;
    tlbl_nxt_d = bus.sw_tlbl_nxt;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        if (!bus.sw_tlbl_we) begin
          tlbl_we_d  = 1'b1;
          tlbl_idx_d = cnt_q;
          tlbl_nxt_d = '0;
        end
        if (bus.flush_req) begin
          cnt_d = '0;
        end else if (!bus.sw_tlbl_we) begin
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + P'(1);
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = bus.flush_req ? FLUSH : IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Hold extends one cycle past DONE so the last flush write lands first.
    busy_d = (state_q != IDLE) || (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  assign bus.tlbl_we    = tlbl_we_q;
  assign bus.tlbl_idx   = tlbl_idx_q;
  assign bus.tlbl_nxt   = tlbl_nxt_q;
  assign bus.tlbh_we    = tlbh_we_q;
  assign bus.tlbh_idx   = tlbh_idx_q;
  assign bus.tlbh_nxt   = tlbh_nxt_q;
  assign bus.fetch_hold = busy_q;
  assign bus.flush_busy = busy_q;
  assign bus.flush_done = done_q;
endmodule
